// File: rtl/pixel_plot_arbiter.sv
// pixel_plot_arbiter: round-robin merge of two pixel streams onto one registered, clipped VGA write port.
// Defining PIXEL_ARB_STATS_EN adds 16-bit plotted/clipped pixel counters; otherwise both count ports read 0.
module pixel_plot_arbiter #(
  parameter logic [7:0] WIDTH  = 8'd160,
  parameter logic [7:0] HEIGHT = 8'd120
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        stall,
  input  logic        a_valid,
  input  logic [7:0]  a_x,
  input  logic [7:0]  a_y,
  input  logic [2:0]  a_colour,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [7:0]  b_x,
  input  logic [7:0]  b_y,
  input  logic [2:0]  b_colour,
  output logic        b_ready,
  output logic [7:0]  out_x,
  output logic [7:0]  out_y,
  output logic [2:0]  out_colour,
  output logic        plot,
  output logic [15:0] plotted_count,
  output logic [15:0] clipped_count
);

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_t;

  ptr_t       ptr_r;
  ptr_t       ptr_nxt_s;
  logic       a_ready_s;
  logic       b_ready_s;
  logic       xfer_a_s;
  logic       xfer_b_s;
  logic       xfer_s;
  logic       in_frame_s;
  logic [7:0] sel_x_s;
  logic [7:0] sel_y_s;
  logic [2:0] sel_colour_s;
  logic [7:0] out_x_r;
  logic [7:0] out_y_r;
  logic [2:0] out_colour_r;
  logic       plot_r;

  // Grant: lone valid channel wins, contention goes to the pointer; reset and stall block all grants
  always_comb begin
    a_ready_s = 1'b0;
    b_ready_s = 1'b0;
    if (!resetn || stall) begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
    end else begin
      case ({a_valid, b_valid})
        2'b10: a_ready_s = 1'b1;
        2'b01: b_ready_s = 1'b1;
        2'b11: begin
          a_ready_s = (ptr_r == PTR_A);
          b_ready_s = (ptr_r == PTR_B);
        end
        default: begin
          a_ready_s = 1'b0;
          b_ready_s = 1'b0;
        end
      endcase
    end
  end

  assign a_ready  = a_ready_s;
  assign b_ready  = b_ready_s;
  assign xfer_a_s = a_valid & a_ready_s;
  assign xfer_b_s = b_valid & b_ready_s;
  assign xfer_s   = xfer_a_s | xfer_b_s;

  // Select the transferring pixel and hand priority to the other channel
  always_comb begin
    ptr_nxt_s    = ptr_r;
    sel_x_s      = a_x;
    sel_y_s      = a_y;
    sel_colour_s = a_colour;
    if (xfer_b_s) begin
      ptr_nxt_s    = PTR_A;
      sel_x_s      = b_x;
      sel_y_s      = b_y;
      sel_colour_s = b_colour;
    end else if (xfer_a_s) begin
      ptr_nxt_s    = PTR_B;
      sel_x_s      = a_x;
      sel_y_s      = a_y;
      sel_colour_s = a_colour;
    end else begin
      ptr_nxt_s    = ptr_r;
      sel_x_s      = a_x;
      sel_y_s      = a_y;
      sel_colour_s = a_colour;
    end
  end

  assign in_frame_s = (sel_x_s < WIDTH) && (sel_y_s < HEIGHT);

  // Priority pointer register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_r <= PTR_A;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Output register: clipped pixels still load the data but never raise plot
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_x_r      <= 8'd0;
      out_y_r      <= 8'd0;
      out_colour_r <= 3'd0;
      plot_r       <= 1'b0;
    end else if (xfer_s) begin
      out_x_r      <= sel_x_s;
      out_y_r      <= sel_y_s;
      out_colour_r <= sel_colour_s;
      plot_r       <= in_frame_s;
    end else begin
      plot_r       <= 1'b0;
    end
  end

  assign out_x      = out_x_r;
  assign out_y      = out_y_r;
  assign out_colour = out_colour_r;
  assign plot       = plot_r;

`ifdef PIXEL_ARB_STATS_EN
  logic        clip_r;
  logic [15:0] plotted_r;
  logic [15:0] clipped_r;

  // Counters advance in the cycle the pixel occupies the output register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clip_r    <= 1'b0;
      plotted_r <= 16'd0;
      clipped_r <= 16'd0;
    end else begin
      clip_r    <= xfer_s & ~in_frame_s;
      plotted_r <= plotted_r + {15'd0, plot_r};
      clipped_r <= clipped_r + {15'd0, clip_r};
    end
  end

  assign plotted_count = plotted_r;
  assign clipped_count = clipped_r;
`else
  assign plotted_count = 16'd0;
  assign clipped_count = 16'd0;
`endif

endmodule

// File: doc/pixel_plot_arbiter.md
Name: pixel_plot_arbiter

Overview:
- Sits directly downstream of the pixel-generating drawers (spikes drawer, player sprite drawer) and directly upstream of the VGA adapter's single write port.
- Merges two pixel streams onto one registered x/y/colour/plot output.
  - Each input stream uses a valid/ready handshake.
  - Arbitration between the streams is round-robin.
- Discards pixels outside the visible frame so that drawers overrunning the screen edge never write to the adapter.

Parameters:
- WIDTH, 160, visible columns; a pixel with x >= WIDTH is clipped.
- HEIGHT, 120, visible rows; a pixel with y >= HEIGHT is clipped.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- stall  in  1  when high, no grants are issued (used during screen clear).
- a_valid  in  1  channel A pixel valid.
- a_x  in  8  channel A column.
- a_y  in  8  channel A row.
- a_colour  in  3  channel A colour.
- a_ready  out  1  channel A pixel accepted this cycle.
- b_valid, b_x, b_y, b_colour, b_ready: identical to the channel A ports, for channel B.
- out_x  out  8  column to the VGA adapter.
- out_y  out  8  row to the VGA adapter.
- out_colour  out  3  colour to the VGA adapter.
- plot  out  1  write enable to the VGA adapter.
- plotted_count  out  16  number of pixels written (optional feature).
- clipped_count  out  16  number of pixels discarded (optional feature).

Behaviour:
- Reset (asynchronous, resetn=0):
  - out_x=0, out_y=0, out_colour=0, plot=0.
  - Priority pointer = A.
  - Both counters = 0.
  - a_ready and b_ready are forced to 0 while resetn is low.
- Ready generation (combinational from current inputs and pointer):
  - stall=1: a_ready=0 and b_ready=0.
  - Only a_valid=1: a_ready=1.
  - Only b_valid=1: b_ready=1.
  - Both valid: the channel named by the pointer gets ready=1; the other gets 0.
  - Neither valid: both ready=0.
- Transfer: occurs on a channel when valid & ready at the rising edge. At most one transfer per cycle.
- Pointer update:
  - After a transfer on A, the pointer becomes B; after a transfer on B, it becomes A.
  - The pointer is unchanged in cycles with no transfer.
  - With both channels continuously valid, grants alternate A, B, A, B...
- Output register, one-cycle latency from transfer to plot:
  - On a transfer, the next cycle has out_x/out_y/out_colour equal to the transferred pixel.
  - plot=1 in that cycle only if x < WIDTH and y < HEIGHT.
- Clipped pixel:
  - It is still accepted (ready=1, the handshake completes), so upstream never deadlocks.
  - plot=0 in the following cycle; out_x/out_y/out_colour still update (don't-care to the adapter).
- Cycles with no transfer: plot=0 the next cycle; out_x/out_y/out_colour hold their previous values.
- Widths: comparisons are unsigned 8-bit. Boundary cases:
  - x=159, y=119: plotted.
  - x=160: clipped.
  - y=120: clipped.
  - x=255: clipped.
- Simultaneous stall rise with valid: no transfer that cycle; the pixel is held by upstream. The inputs are not captured, so no data is lost.
- Reset mid-stream: any pixel in the output register is dropped (plot=0 immediately). Upstream must re-present its pixel because ready was 0.
- Valid-drop rule: a channel may drop valid without a transfer; the arbiter holds no per-channel state beyond the pointer.

Optional Feature:
- Macro: PIXEL_ARB_STATS_EN.
- Defined:
  - plotted_count increments by 1 on every cycle in which plot=1.
  - clipped_count increments by 1 for every transfer that is clipped, in the same cycle the clipped pixel would have been written.
  - Both counters are 16-bit, wrap from 65535 to 0, and reset to 0.
- Undefined: both count ports are tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset check: hold resetn=0 with a_valid=b_valid=1 and stall=0 -> a_ready=b_ready=0 and plot=0. Release reset with a (10,5,3'b101) and b (20,6,3'b010) both valid for 4 cycles -> grants A,B,A,B. Plot is seen one cycle after each grant, with out_x sequence 10,20,10,20 and out_colour 5,2,5,2.
- Single channel: b_valid only, streaming x=0..3, y=7 -> b_ready=1 every cycle, plot=1 for 4 consecutive cycles starting 1 cycle later, out_x=0,1,2,3.
- Clipping boundaries: A sends (159,119), (160,0), (0,120), (255,255) -> b_ready is irrelevant, all 4 are accepted, plot=1,0,0,0. With PIXEL_ARB_STATS_EN defined: plotted_count=1, clipped_count=3.
- Stall: both valid, stall=1 for 3 cycles, then 0 -> no ready and no plot during the stall. The first grant after the stall goes to the pointer's channel, which is unchanged from before the stall.
- Reset mid-operation: assert resetn=0 asynchronously between clock edges on the cycle after an A transfer -> plot falls to 0 without waiting for a clock edge. After release, the pointer is A and the counters are 0.
- Counter wrap (PIXEL_ARB_STATS_EN defined): 65536 plotted pixels -> plotted_count reads 0. With the macro undefined, both counters stay 0 throughout every test.
